// File: rtl/ascon_seq_ctrl.sv
// ascon_seq_ctrl
// Sequences one message through an ASCON-128 core. A descriptor (key, nonce,
// AD and PT block counts) is accepted in IDLE. The controller then pulses
// core_start_o and waits out the p12 initialisation. Next it pulls blocks from
// the input stream (AD first, then PT) and strobes each one into the core,
// leaving the p6 gap after every AD block. It returns each cipher block and
// finally the tag. Any wait on the core is bounded by TIMEOUT.
//
// Ports
//   clock_i, reset_i             clock, synchronous active-high reset
//   cfg_valid_i / cfg_ready_o    descriptor handshake (ready only in IDLE)
//   key_i, nonce_i               sampled on the descriptor handshake
//   ad_cnt_i, pt_cnt_i           AD block count (0..MAX_AD), PT block count (1..MAX_PT)
//   s_data_i/s_valid_i/s_ready_o input block stream (ready only in FETCH)
//   core_*_o                     start pulse, block + strobe, registered key/nonce
//   core_*_i                     cipher + valid, tag + end from the core
//   ct_data_o/ct_valid_o         registered cipher block, one-cycle valid
//   tag_o/tag_valid_o            registered tag, one-cycle valid
//   err_o                        one-cycle pulse on timeout or bad descriptor
module ascon_seq_ctrl #(
  parameter int DATA_W   = 64,
  parameter int KEY_W    = 128,
  parameter int MAX_AD   = 4,
  parameter int MAX_PT   = 8,
  parameter int INIT_CYC = 12,
  parameter int GAP_CYC  = 6,
  parameter int TIMEOUT  = 64
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        cfg_valid_i,
  output logic                        cfg_ready_o,
  input  logic [KEY_W-1:0]            key_i,
  input  logic [KEY_W-1:0]            nonce_i,
  input  logic [$clog2(MAX_AD+1)-1:0] ad_cnt_i,
  input  logic [$clog2(MAX_PT+1)-1:0] pt_cnt_i,
  input  logic [DATA_W-1:0]           s_data_i,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  output logic                        core_start_o,
  output logic [DATA_W-1:0]           core_data_o,
  output logic                        core_data_valid_o,
  output logic [KEY_W-1:0]            core_key_o,
  output logic [KEY_W-1:0]            core_nonce_o,
  input  logic [DATA_W-1:0]           core_cipher_i,
  input  logic                        core_cipher_valid_i,
  input  logic [KEY_W-1:0]            core_tag_i,
  input  logic                        core_end_i,
  output logic [DATA_W-1:0]           ct_data_o,
  output logic                        ct_valid_o,
  output logic [KEY_W-1:0]            tag_o,
  output logic                        tag_valid_o,
  output logic                        err_o
);
  localparam int AD_W = $clog2(MAX_AD+1);
  localparam int PT_W = $clog2(MAX_PT+1);
  // One shared timer serves the init, gap and timeout waits; INIT_CYC and
  // GAP_CYC are expected not to exceed TIMEOUT.
  localparam int TM_W = $clog2(TIMEOUT+1);

  localparam logic [AD_W-1:0] MAX_AD_V  = AD_W'(MAX_AD);
  localparam logic [PT_W-1:0] MAX_PT_V  = PT_W'(MAX_PT);
  localparam logic [TM_W-1:0] INIT_LAST = TM_W'(INIT_CYC-1);
  localparam logic [TM_W-1:0] GAP_LAST  = TM_W'(GAP_CYC-1);
  localparam logic [TM_W-1:0] TMO_LAST  = TM_W'(TIMEOUT-1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_INIT, S_FETCH, S_ISSUE, S_WAIT_AD, S_WAIT_CT, S_WAIT_TAG
  } state_e;

  state_e              state_q;
  logic [KEY_W-1:0]    key_q, nonce_q, tag_q;
  logic [DATA_W-1:0]   data_q, ct_q;
  logic [AD_W-1:0]     ad_cnt_q, ad_idx_q;
  logic [PT_W-1:0]     pt_cnt_q, pt_idx_q;
  logic                pt_phase_q;
  logic [TM_W-1:0]     timer_q;
  logic                ct_vld_q, tag_vld_q, err_q;
  logic                bad_desc;

  assign bad_desc = (pt_cnt_i == '0) || (pt_cnt_i > MAX_PT_V) || (ad_cnt_i > MAX_AD_V);

  // Handshake/strobe outputs are decoded straight from the state register.
  assign cfg_ready_o       = (state_q == S_IDLE);
  assign s_ready_o         = (state_q == S_FETCH);
  assign core_start_o      = (state_q == S_START);
  assign core_data_valid_o = (state_q == S_ISSUE);
  assign core_data_o       = data_q;
  assign core_key_o        = key_q;
  assign core_nonce_o      = nonce_q;
  assign ct_data_o         = ct_q;
  assign ct_valid_o        = ct_vld_q;
  assign tag_o             = tag_q;
  assign tag_valid_o       = tag_vld_q;
  assign err_o             = err_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      nonce_q    <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      ct_q       <= '0;
      ad_cnt_q   <= '0;
      ad_idx_q   <= '0;
      pt_cnt_q   <= '0;
      pt_idx_q   <= '0;
      pt_phase_q <= 1'b0;
      timer_q    <= '0;
      ct_vld_q   <= 1'b0;
      tag_vld_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ct_vld_q  <= 1'b0;
      tag_vld_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: if (cfg_valid_i) begin
          if (bad_desc) begin
            err_q <= 1'b1;           // consume the descriptor, leave core alone
          end else begin
            key_q      <= key_i;
            nonce_q    <= nonce_i;
            ad_cnt_q   <= ad_cnt_i;
            pt_cnt_q   <= pt_cnt_i;
            ad_idx_q   <= '0;
            pt_idx_q   <= '0;
            pt_phase_q <= (ad_cnt_i == '0);  // no AD: go straight to PT blocks
            state_q    <= S_START;
          end
        end
        S_START: begin
          timer_q <= '0;
          state_q <= S_INIT;
        end
        S_INIT: begin
          if (timer_q == INIT_LAST) begin
            timer_q <= '0;
            state_q <= S_FETCH;
          end else begin
            timer_q <= timer_q + TM_W'(1);
          end
        end
        S_FETCH: if (s_valid_i) begin
          data_q  <= s_data_i;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          timer_q <= '0;
          if (!pt_phase_q) begin
            ad_idx_q <= ad_idx_q + AD_W'(1);
            if (ad_idx_q == ad_cnt_q - AD_W'(1)) pt_phase_q <= 1'b1;
            state_q <= S_WAIT_AD;
          end else begin
            state_q <= S_WAIT_CT;
          end
        end
        S_WAIT_AD: begin
          if (timer_q == GAP_LAST) begin
            timer_q <= '0;
            state_q <= S_FETCH;
          end else begin
            timer_q <= timer_q + TM_W'(1);
          end
        end
        S_WAIT_CT: begin
          // A cipher arriving on the expiry cycle still counts.
          if (core_cipher_valid_i) begin
            ct_q     <= core_cipher_i;
            ct_vld_q <= 1'b1;
            timer_q  <= '0;
            pt_idx_q <= pt_idx_q + PT_W'(1);
            state_q  <= (pt_idx_q == pt_cnt_q - PT_W'(1)) ? S_WAIT_TAG : S_FETCH;
          end else if (timer_q == TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + TM_W'(1);
          end
        end
        S_WAIT_TAG: begin
          if (core_end_i) begin
            tag_q     <= core_tag_i;
            tag_vld_q <= 1'b1;
            state_q   <= S_IDLE;
          end else if (timer_q == TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + TM_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_seq_ctrl.sv
// Scoreboard bench for ascon_seq_ctrl. The stimulus pushes the expected
// ct/tag/err events. A monitor pops them whenever the DUT pulses an output.
// A simple core model answers each PT strobe with data ^ key[63:0]. It answers
// the final block with a tag equal to key ^ nonce.
module tb_ascon_seq_ctrl;
  localparam int INIT_CYC = 12;
  localparam int TIMEOUT  = 64;
  localparam int LAT      = 3;

  logic         clk = 1'b0, rst_i = 1'b1;
  logic         cfg_valid_i = 1'b0, cfg_ready_o;
  logic [127:0] key_i = '0, nonce_i = '0;
  logic [2:0]   ad_cnt_i = '0;
  logic [3:0]   pt_cnt_i = '0;
  logic [63:0]  s_data_i = '0;
  logic         s_valid_i = 1'b0, s_ready_o;
  logic         core_start_o, core_data_valid_o;
  logic [63:0]  core_data_o;
  logic [127:0] core_key_o, core_nonce_o;
  logic [63:0]  core_cipher_i = '0;
  logic         core_cipher_valid_i = 1'b0;
  logic [127:0] core_tag_i = '0;
  logic         core_end_i = 1'b0;
  logic [63:0]  ct_data_o;
  logic         ct_valid_o, tag_valid_o, err_o;
  logic [127:0] tag_o;

  ascon_seq_ctrl dut (
    .clock_i(clk), .reset_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .key_i(key_i), .nonce_i(nonce_i), .ad_cnt_i(ad_cnt_i), .pt_cnt_i(pt_cnt_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .core_start_o(core_start_o), .core_data_o(core_data_o),
    .core_data_valid_o(core_data_valid_o), .core_key_o(core_key_o),
    .core_nonce_o(core_nonce_o), .core_cipher_i(core_cipher_i),
    .core_cipher_valid_i(core_cipher_valid_i), .core_tag_i(core_tag_i),
    .core_end_i(core_end_i), .ct_data_o(ct_data_o), .ct_valid_o(ct_valid_o),
    .tag_o(tag_o), .tag_valid_o(tag_valid_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; logic [127:0] val; } exp_t;  // 0 ct, 1 tag, 2 err
  exp_t        exp_q[$];
  logic [63:0] blk_q[$];   // blocks the core must see, in order
  logic [63:0] src_q[$];   // blocks the stream source offers
  logic [63:0] blk[16];

  int nerr = 0, nchk = 0;
  int n_ct = 0, n_tag = 0, n_start = 0, strobes = 0, pt_seen = 0;
  int last_ct_cyc = 0, err_cyc = 0, first_cyc = -1, hs_cyc = 0;
  int m_ad = 0, m_pt = 0, ct_cd = 0, end_cd = 0;
  bit m_no_end = 0, src_pause = 0;
  logic [63:0] pend = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    nchk++; nerr++;
    $display("FAIL %s", name);
  endtask

  task automatic pop_cmp(input int kind, input logic [127:0] val, input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      fail_now({name, "_unexpected"});
    end else begin
      e = exp_q.pop_front();
      chk({name, "_kind"}, 128'(kind), 128'(e.kind));
      if (kind != 2 && kind == e.kind) chk({name, "_val"}, val, e.val);
    end
  endtask

  // Monitor
  always @(negedge clk) if (!rst_i) begin
    if (ct_valid_o)  begin n_ct++;  last_ct_cyc = cyc; pop_cmp(0, 128'(ct_data_o), "ct"); end
    if (tag_valid_o) begin n_tag++; pop_cmp(1, tag_o, "tag"); end
    if (err_o)       begin err_cyc = cyc; pop_cmp(2, '0, "err"); end
  end

  // Core model
  initial forever begin
    @(negedge clk);
    core_cipher_valid_i = 1'b0;
    core_end_i = 1'b0;
    if (rst_i) begin
      ct_cd = 0; end_cd = 0; strobes = 0; pt_seen = 0;
    end else begin
      if (core_start_o) begin n_start++; strobes = 0; pt_seen = 0; first_cyc = -1; end
      if (end_cd > 0) begin
        end_cd--;
        if (end_cd == 0) begin core_end_i = 1'b1; core_tag_i = core_key_o ^ core_nonce_o; end
      end
      if (ct_cd > 0) begin
        ct_cd--;
        if (ct_cd == 0) begin
          core_cipher_valid_i = 1'b1;
          core_cipher_i = pend ^ core_key_o[63:0];
          pt_seen++;
          if (pt_seen == m_pt && !m_no_end) end_cd = LAT;
        end
      end
      if (core_data_valid_o) begin
        strobes++;
        if (first_cyc < 0) first_cyc = cyc;
        if (blk_q.size() == 0) fail_now("core_data_unexpected");
        else chk("core_data", 128'(core_data_o), 128'(blk_q.pop_front()));
        if (strobes > m_ad) begin pend = core_data_o; ct_cd = LAT; end
      end
    end
  end

  // Stream source: a handshake is pending when valid is offered while ready is high.
  initial begin
    bit hs_pend = 0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        hs_pend = 0; s_valid_i = 1'b0;
      end else begin
        if (hs_pend) begin void'(src_q.pop_front()); hs_pend = 0; end
        if (src_q.size() > 0 && !src_pause) begin
          s_valid_i = 1'b1; s_data_i = src_q[0]; hs_pend = s_ready_o;
        end else begin
          s_valid_i = 1'b0;
        end
      end
    end
  end

  task automatic send_cfg(input logic [127:0] k, input logic [127:0] n,
                          input logic [2:0] a, input logic [3:0] p);
    int t = 0;
    @(negedge clk);
    while (!cfg_ready_o && t < 500) begin @(negedge clk); t++; end
    if (!cfg_ready_o) fail_now("cfg_ready_timeout");
    cfg_valid_i = 1'b1; key_i = k; nonce_i = n; ad_cnt_i = a; pt_cnt_i = p;
    @(negedge clk);
    cfg_valid_i = 1'b0;
    hs_cyc = cyc;
  endtask

  task automatic run_msg(input logic [127:0] k, input logic [127:0] n, input int a, input int p);
    for (int i = 0; i < a + p; i++) begin src_q.push_back(blk[i]); blk_q.push_back(blk[i]); end
    for (int i = 0; i < p; i++) exp_q.push_back('{0, 128'(blk[a+i] ^ k[63:0])});
    if (m_no_end) exp_q.push_back('{2, '0});
    else          exp_q.push_back('{1, k ^ n});
    m_ad = a; m_pt = p;
    send_cfg(k, n, 3'(a), 4'(p));
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin fail_now({name, "_drain_timeout"}); exp_q.delete(); end
    repeat (3) @(negedge clk);
  endtask

  task automatic fill_blk(input logic [63:0] base);
    for (int i = 0; i < 16; i++) blk[i] = base + 64'h0101_0101_0101_0101 * 64'(i);
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_ctrl"}, 128'({cfg_ready_o, s_ready_o, core_start_o, core_data_valid_o,
                               ct_valid_o, tag_valid_o, err_o}), 128'(7'b1000000));
    chk({name, "_data"}, 128'(core_data_o | ct_data_o), '0);
    chk({name, "_key"}, core_key_o | core_nonce_o | tag_o, '0);
  endtask

  initial begin
    int c0, t0, s0, t;
    bit bad;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst_i = 1'b0;

    // 1: reference vector, ad=1 pt=3
    blk[0] = 64'h4120746f20428000; blk[1] = 64'h5244562061752054;
    blk[2] = 64'h6927626172206365; blk[3] = 64'h20736f6972203f80;
    c0 = n_ct; t0 = n_tag;
    run_msg(128'h8a55114d1cb6a9a2be263d4d7aecaaff, 128'h4ed0ec0b98c529b7c8cddf37bcd0284a, 1, 3);
    wait_done("t1");
    chk("t1_ct_pulses", 128'(n_ct - c0), 128'(3));
    chk("t1_tag_pulses", 128'(n_tag - t0), 128'(1));
    chk("t1_cfg_ready", 128'(cfg_ready_o), 128'(1));

    // 2: ad=0 pt=1, first strobe latency
    fill_blk(64'h1000_2000_3000_4000);
    c0 = n_ct; t0 = n_tag;
    run_msg(128'h0123456789abcdef_fedcba9876543210, 128'h55, 0, 1);
    wait_done("t2");
    chk("t2_latency", 128'(first_cyc - hs_cyc + 1), 128'(INIT_CYC + 3));
    chk("t2_strobes", 128'(strobes), 128'(1));
    chk("t2_pulses", 128'({n_ct - c0, n_tag - t0}), 128'({32'd1, 32'd1}));

    // 3: stream stalls in FETCH
    fill_blk(64'hA000_0000_0000_00A0);
    src_pause = 1;
    run_msg(128'hdead_beef, 128'hcafe, 1, 2);
    bad = 0;
    repeat (14) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (core_data_valid_o || err_o) bad = 1;
    end
    chk("t3_stall_quiet", 128'(bad), '0);
    chk("t3_s_ready", 128'(s_ready_o), 128'(1));
    src_pause = 0;
    wait_done("t3");

    // 4: core never ends -> timeout in WAIT_TAG
    fill_blk(64'h7777_0000_1111_0000);
    m_no_end = 1; t0 = n_tag;
    run_msg(128'h99, 128'h66, 0, 2);
    wait_done("t4");
    chk("t4_tmo_delay", 128'(err_cyc - last_ct_cyc), 128'(TIMEOUT));
    chk("t4_no_tag", 128'(n_tag - t0), '0);
    chk("t4_cfg_ready", 128'(cfg_ready_o), 128'(1));
    m_no_end = 0;

    // 5: bad descriptors, then the largest legal one
    s0 = n_start;
    exp_q.push_back('{2, '0}); send_cfg(128'h1, 128'h2, 3'd0, 4'd0); wait_done("t5a");
    exp_q.push_back('{2, '0}); send_cfg(128'h1, 128'h2, 3'd5, 4'd1); wait_done("t5b");
    exp_q.push_back('{2, '0}); send_cfg(128'h1, 128'h2, 3'd0, 4'd9); wait_done("t5c");
    chk("t5_no_start", 128'(n_start - s0), '0);
    fill_blk(64'h0F0F_0000_F0F0_0001);
    c0 = n_ct;
    run_msg(128'hfeed_face_0000_1234, 128'h0bad_f00d, 4, 8);
    wait_done("t5d");
    chk("t5_max_ct", 128'(n_ct - c0), 128'(8));

    // 6: reset during the second PT wait
    fill_blk(64'h3333_4444_5555_6666);
    run_msg(128'h1234, 128'h5678, 0, 3);
    t = 0;
    while (strobes < 2 && t < 500) begin @(negedge clk); t++; end
    if (strobes < 2) fail_now("t6_second_strobe_timeout");
    rst_i = 1'b1;
    exp_q.delete(); blk_q.delete(); src_q.delete();
    @(negedge clk);
    rst_i = 1'b0;
    chk_reset_outs("t6_reset");
    fill_blk(64'h8888_9999_AAAA_BBBB);
    c0 = n_ct; t0 = n_tag;
    run_msg(128'habc, 128'hdef, 1, 1);
    wait_done("t6");
    chk("t6_pulses", 128'({n_ct - c0, n_tag - t0}), 128'({32'd1, 32'd1}));

    chk("blk_drained", 128'(blk_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
